// File: rtl/dprc_pkg.sv
// dprc_pkg: shared state encoding, lane width and lane-count helper for dprc
package dprc_pkg;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    localparam int LANE_W = 8;
    function automatic int lanes(input int dw);
        return dw / LANE_W;
    endfunction
endpackage

// File: rtl/dprc_fill.sv
// dprc_fill: fill sequencer owning the write path while busy
module dprc_fill
    import dprc_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter logic [DW-1:0] FILL = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] fa,
    output logic [DW-1:0] fd
);
    state_t state, nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        nxt     = clr ? ST_CLEAR : (state == ST_CLEAR && cnt == '1) ? ST_IDLE : state;
        cnt_nxt = clr ? '0 : (state == ST_CLEAR) ? cnt + 1'b1 : cnt;
        busy    = state == ST_CLEAR;
        fa      = cnt;
        fd      = FILL;
    end
endmodule

// File: rtl/dprc.sv
// dprc: dual-port RAM with byte-lane write mask and fill sequencer; DPRC_BYPASS_EN selects write-first collisions
module dprc
    import dprc_pkg::*;
#(
    parameter int KB = 1,
    parameter int DW = 8,
    parameter logic [DW-1:0] FILL = '0,
    localparam int WORDS = KB * 1024,
    localparam int AW = $clog2(WORDS),
    localparam int LANES = lanes(DW)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    output logic             busy,
    input  logic             ce1,
    input  logic [AW-1:0]    a1,
    output logic [DW-1:0]    q1,
    input  logic             ce2,
    input  logic             we2,
    input  logic [LANES-1:0] be2,
    input  logic [AW-1:0]    a2,
    input  logic [DW-1:0]    d2
);
    if (DW % LANE_W != 0) begin : g_bad_dw
        $error("dprc: DW must be a multiple of 8");
    end
    logic [DW-1:0] mem [WORDS];
    logic [AW-1:0] fa;
    logic [DW-1:0] fd, rd;
    dprc_fill #(.AW(AW), .DW(DW), .FILL(FILL)) u_fill (
        .clock(clock),
        .reset(reset),
        .clr(clr),
        .busy(busy),
        .fa(fa),
        .fd(fd)
    );
    always_ff @(posedge clock) begin
        if (busy)
            mem[fa] <= fd;
        else if (ce2 && !we2)
            for (int i = 0; i < LANES; i++)
                if (be2[i])
                    mem[a2][i*LANE_W +: LANE_W] <= d2[i*LANE_W +: LANE_W];
    end
    always_comb begin
        rd = mem[a1];
`ifdef DPRC_BYPASS_EN
        for (int i = 0; i < LANES; i++)
            if (ce2 && !we2 && a1 == a2 && be2[i])
                rd[i*LANE_W +: LANE_W] = d2[i*LANE_W +: LANE_W];
`endif
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q1 <= '0;
        else if (ce1)
            q1 <= busy ? fd : rd;
    end
endmodule

// File: tb/tb_dprc.sv
// tb_dprc: scoreboard bench for dprc (KB=1, DW=16, FILL=A5A5)
module tb_dprc;
    localparam logic [15:0] FILLV = 16'hA5A5;
    logic        clock = 0, reset = 1, clr = 0, busy;
    logic        ce1 = 0, ce2 = 0, we2 = 1;
    logic [9:0]  a1 = '0, a2 = '0;
    logic [1:0]  be2 = '0;
    logic [15:0] d2 = '0, q1;
    logic [15:0] model [1024];
    int errors = 0, checks = 0;
    typedef struct {string tag; logic [15:0] exp;} exp_t;
    exp_t sbq[$];

    dprc #(.KB(1), .DW(16), .FILL(FILLV)) dut (
        .clock(clock), .reset(reset), .clr(clr), .busy(busy),
        .ce1(ce1), .a1(a1), .q1(q1),
        .ce2(ce2), .we2(we2), .be2(be2), .a2(a2), .d2(d2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, q1, e.exp);
        end
    endtask

    task automatic rd(input string tag, input int addr, input logic [15:0] exp);
        ce1 = 1;
        a1 = addr[9:0];
        sbq.push_back('{tag, exp});
        step();
        ce1 = 0;
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] m = old;
        for (int i = 0; i < 2; i++)
            if (be[i]) m[i*8 +: 8] = d[i*8 +: 8];
        return m;
    endfunction

    task automatic set_wr(input int addr, input logic [15:0] d, input logic [1:0] be, input logic ce, input logic we);
        ce2 = ce; we2 = we; a2 = addr[9:0]; d2 = d; be2 = be;
    endtask

    task automatic clr_wr();
        ce2 = 0; we2 = 1; be2 = '0;
    endtask

    task automatic wr(input int addr, input logic [15:0] d, input logic [1:0] be, input logic ce, input logic we);
        set_wr(addr, d, be, ce, we);
        if (ce && !we) model[addr] = merge(model[addr], d, be);
        step();
        clr_wr();
    endtask

    task automatic wait_idle(input string tag, input int pre);
        int n = pre;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        chk(tag, n, 1024);
        foreach (model[i]) model[i] = FILLV;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] old;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_q1", q1, 0);
        reset = 0;
        wait_idle("fill_len", 0);
        chk("idle_busy", busy, 0);
        rd("rd0", 0, FILLV);
        rd("rd511", 511, FILLV);
        rd("rd1023", 1023, FILLV);

        wr(5, 16'h1234, 2'b01, 1, 0);
        rd("lane_lo", 5, model[5]);
        chk("lane_lo_model", model[5], 16'hA534);
        wr(6, 16'hFFFF, 2'b11, 1, 1);
        rd("we2_hi", 6, FILLV);
        wr(7, 16'hFFFF, 2'b11, 0, 0);
        rd("ce2_lo", 7, FILLV);
        wr(8, 16'hFFFF, 2'b00, 1, 0);
        rd("be_zero", 8, FILLV);

        wr(9, 16'h0000, 2'b11, 1, 0);
        old = model[9];
        set_wr(9, 16'hBEEF, 2'b11, 1, 0);
`ifdef DPRC_BYPASS_EN
        rd("coll_full", 9, merge(old, 16'hBEEF, 2'b11));
`else
        rd("coll_full", 9, old);
`endif
        model[9] = merge(old, 16'hBEEF, 2'b11);
        clr_wr();
        rd("coll_after", 9, 16'hBEEF);
        a1 = 5;
        step();
        chk("hold", q1, 16'hBEEF);

        old = model[10];
        set_wr(10, 16'h1234, 2'b10, 1, 0);
`ifdef DPRC_BYPASS_EN
        rd("coll_part", 10, 16'h12A5);
`else
        rd("coll_part", 10, old);
`endif
        model[10] = merge(old, 16'h1234, 2'b10);
        clr_wr();
        rd("part_after", 10, 16'h12A5);

        clr = 1;
        step();
        clr = 0;
        chk("clr_busy", busy, 1);
        repeat (299) step();
        clr = 1;
        step();
        clr = 0;
        rd("fill_rd", 5, FILLV);
        set_wr(0, 16'h1111, 2'b11, 1, 0);
        step();
        clr_wr();
        wait_idle("refill_len", 2);
        rd("drop_w0", 0, FILLV);
        rd("refill5", 5, FILLV);
        rd("refill9", 9, FILLV);
        rd("refill1023", 1023, FILLV);

        wr(9, 16'hBEEF, 2'b11, 1, 0);
        rd("pre_rst", 9, 16'hBEEF);
        ce1 = 1;
        a1 = 9;
        #2 reset = 1;
        #1;
        chk("async_q1", q1, 0);
        chk("async_busy", busy, 1);
        ce1 = 0;
        repeat (2) step();
        reset = 0;
        wait_idle("rst_fill_len", 0);
        rd("post_rst9", 9, FILLV);
        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dprc.md
# dprc

Parametrised dual-port block RAM with byte-lane write masking and a hardware fill sequencer. Port 1 is a registered read port and port 2 a masked write port, as with our existing video and character RAMs. After reset, or on request, the block writes a fill value to every word on its own and flags `busy` while doing so. It sits between the CPU bus decode and the video fetch logic wherever a RAM must start from a known state without software clearing it.

## Interface
- `KB`, default 1: depth in KiB of words; WORDS = KB*1024, AW = $clog2(WORDS).
- `DW`, default 8: data width in bits; must be a multiple of 8; LANES = DW/8.
- `FILL`, default 0: DW-bit value written by the fill sequencer.
- `clock` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `clr` in 1: fill request, sampled in any cycle.
- `busy` out 1: high while the fill sequencer owns the write path.
- `ce1` in 1: read enable.
- `a1` in AW: read address.
- `q1` out DW: registered read data.
- `ce2` in 1: write port enable.
- `we2` in 1: write strobe, active-low, matching the existing RAMs.
- `be2` in LANES: byte-lane enables, active-high; bit i selects `d2[8i+7:8i]`.
- `a2` in AW: write address.
- `d2` in DW: write data.

## Operation
- States are CLEAR and IDLE. `reset` forces CLEAR with fill counter = 0, `busy` = 1 and `q1` = 0. Memory contents are not reset.
- In CLEAR, each cycle writes FILL to word[counter] and then increments the counter. The write at counter = WORDS-1 moves the block to IDLE. No wrap occurs.
- `clr` in IDLE moves the block to CLEAR with counter = 0 on the next edge.
- `clr` in CLEAR restarts the counter at 0, and the fill completes from 0.
- In CLEAR, port-2 writes are dropped and not queued. A read with `ce1` = 1 loads FILL into `q1`, whatever the address.
- In IDLE, a write occurs when `ce2` = 1 and `we2` = 0. Only lanes with `be2[i]` = 1 are updated. When `be2` = 0, nothing is written.
- In IDLE, a read with `ce1` = 1 loads word[a1] into `q1`. When `ce1` = 0, `q1` holds its value.
- Collision: a read and a write in the same IDLE cycle with a1 == a2. Without the bypass, `q1` gets the old word (read-first).
- Reset during a fill aborts the fill and starts a new one from 0.

## Timing
- Read latency is 1 cycle: the address is presented at edge n and the data is valid after edge n.
- Write takes effect at edge n, and a read of the same address at n+1 sees the new data.
- `busy` is registered. It stays 1 through the edge that performs the last fill write and is 0 from the following cycle.
- A full fill lasts WORDS cycles after the `reset` release, or after the `clr` edge.
- `busy` rises on the edge that samples `clr` in IDLE.

## Configuration
- `DPRC_BYPASS_EN` defined: on a collision, `q1` gets the merged word. Written lanes come from `d2` and the other lanes from the old word (write-first).
- Without the macro: collision behaviour is read-first, and no forwarding logic is built.
- The macro has no effect during CLEAR.

## Structure
- Package `dprc_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_CLEAR`);
  - the `LANE_W = 8` constant;
  - a `lanes(dw)` function returning dw/8.
- Sub-module `dprc_fill`: the state machine, the fill counter and `busy`. It drives the internal write mux (address, data, all-lanes enable).
- The top level owns:
  - the memory array;
  - the lane-masked write;
  - the read register;
  - the optional bypass.
- An elaboration check rejects DW % 8 != 0.

## Test plan
- Reset release, KB=1, DW=16, FILL=16'hA5A5 → `busy` is 1 for 1024 cycles, then 0. Reads of 0, 511 and 1023 return A5A5.
- IDLE write of a2=5, d2=16'h1234, be2=2'b01 over FILL A5A5 → read 5 returns A534.
- Write with `we2`=1, or with `ce2`=0 → the word is unchanged.
- Collision at a1=a2=9: old=0000, d2=BEEF, be2=11 → `q1` = 0000 without `DPRC_BYPASS_EN` and BEEF with it. Read 9 on the next cycle returns BEEF in both builds.
- `clr` at fill counter 300 → the counter restarts at 0 and `busy` lasts 1024 more cycles. A port-2 write during the fill is dropped, and `q1` reads FILL.
- `reset` asserted mid-read in IDLE → `q1` = 0 and `busy` = 1 immediately (asynchronously). The fill then runs from 0.
